// File: rtl/des_pkg.sv
// Shared constants and helpers for the DES key-schedule slice.
//   KEY56_W / HALF_W / SUBKEY_W : PC-1 output, C/D half and subkey widths.
//   SHIFT_SCHED                 : per-round left-rotation amounts for encryption.
//   PC2_TAB                     : PC-2 selection table, 1-indexed from the MSB of C||D.
//   shift_amt()                 : rotation amount for a given direction and round.
//   rotate_half()               : 0/1/2 rotation of a 28-bit half, left or right.
package des_pkg;

  localparam int KEY56_W  = 56;
  localparam int HALF_W   = 28;
  localparam int SUBKEY_W = 48;

  localparam logic [1:0] SHIFT_SCHED [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam int unsigned PC2_TAB [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic [0:0] {StIdle, StRun} ks_state_e;

  // Decryption walks the encryption schedule backwards; its first step is a
  // zero rotation because C16/D16 equal C0/D0.
  function automatic logic [1:0] shift_amt(input logic dir, input logic [3:0] rnd);
    logic [4:0] idx;
    idx = 5'd16 - {1'b0, rnd};
    if (!dir)             return SHIFT_SCHED[rnd];
    else if (rnd == 4'd0) return 2'd0;
    else                  return SHIFT_SCHED[idx[3:0]];
  endfunction

  // dir = 0: rotate left, dir = 1: rotate right.
  function automatic logic [HALF_W-1:0] rotate_half(input logic [HALF_W-1:0] h,
                                                    input logic [1:0] amt,
                                                    input logic dir);
    logic [HALF_W-1:0] r;
    r = h;
    unique case (amt)
      2'd1:    r = dir ? {h[0], h[HALF_W-1:1]} : {h[HALF_W-2:0], h[HALF_W-1]};
      2'd2:    r = dir ? {h[1:0], h[HALF_W-1:2]} : {h[HALF_W-3:0], h[HALF_W-1:HALF_W-2]};
      default: r = h;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/des_key_schedule_pc2.sv
// PC-2 compression permutation, purely combinational.
//   cd     : 56-bit C||D, C in [55:28].
//   subkey : 48-bit round subkey, [47] = PC-2 output bit 1.
module des_key_schedule_pc2
  import des_pkg::*;
(
  input  logic [KEY56_W-1:0]  cd,
  output logic [SUBKEY_W-1:0] subkey
);

  for (genvar i = 0; i < SUBKEY_W; i++) begin : g_bit
    // Table entry n refers to bit n counted from the MSB, i.e. index 56-n.
    localparam int Idx = KEY56_W - int'(PC2_TAB[i]);
    assign subkey[SUBKEY_W-1-i] = cd[Idx];
  end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule fed by the PC-1 output.
//   clk, rst_n    : clock, asynchronous active-low reset.
//   start         : load request, taken only while start_ready is high.
//   decrypt       : captured with start; 0 = K1..K16, 1 = K16..K1.
//   pc1_key       : C0 in [55:28], D0 in [27:0].
//   start_ready   : high while idle.
//   subkey_valid  : subkey present; subkey_ready accepts it.
//   subkey, round : current subkey and its handshake index 0..15.
//   done          : one-cycle pulse after the 16th subkey is accepted.
module des_key_schedule
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                decrypt,
  input  logic [KEY56_W-1:0]  pc1_key,
  output logic                start_ready,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic [SUBKEY_W-1:0] subkey,
  output logic [3:0]          round,
  output logic                done
);

  ks_state_e         state_q;
  logic [HALF_W-1:0] c_q, d_q;
  logic [3:0]        round_q;
  logic              dir_q;
  logic              done_q;

  logic [3:0]        round_nxt;
  logic [1:0]        amt_nxt;
  logic [1:0]        amt_load;

  always_comb begin
    round_nxt = round_q + 4'd1;
    amt_nxt   = shift_amt(dir_q, round_nxt);
    amt_load  = shift_amt(decrypt, 4'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            c_q     <= rotate_half(pc1_key[KEY56_W-1:HALF_W], amt_load, decrypt);
            d_q     <= rotate_half(pc1_key[HALF_W-1:0], amt_load, decrypt);
            round_q <= '0;
            dir_q   <= decrypt;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (subkey_ready) begin
            if (round_q == 4'd15) begin
              round_q <= '0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              round_q <= round_nxt;
              c_q     <= rotate_half(c_q, amt_nxt, dir_q);
              d_q     <= rotate_half(d_q, amt_nxt, dir_q);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign start_ready  = (state_q == StIdle);
  assign subkey_valid = (state_q == StRun);
  assign round        = round_q;
  assign done         = done_q;

  des_key_schedule_pc2 u_pc2 (
    .cd     ({c_q, d_q}),
    .subkey (subkey)
  );

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: a reference key schedule fills a
// scoreboard at each key load; entries are popped at each handshake.
module tb_des_key_schedule;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        decrypt;
  logic [55:0] pc1_key;
  logic        start_ready;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic [3:0]  round;
  logic        done;

  des_key_schedule dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .decrypt      (decrypt),
    .pc1_key      (pc1_key),
    .start_ready  (start_ready),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .subkey       (subkey),
    .round        (round),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [55:0] KeyFips = 56'hF0CCAAF556678F;
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int PT [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef struct {
    logic [47:0] k;
    logic [3:0]  r;
  } exp_t;

  exp_t sb[$];
  int   tot = 0;
  int   bad = 0;

  // Kn from C0||D0 by cumulative single-bit left rotations.
  function automatic logic [47:0] model_k(input logic [55:0] k, input int n);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] o;
    int tot_sh;
    c = k[55:28];
    d = k[27:0];
    tot_sh = 0;
    for (int i = 0; i < n; i++) tot_sh += SH[i];
    for (int s = 0; s < tot_sh; s++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) o[47-i] = cd[56-PT[i]];
    return o;
  endfunction

  task automatic push_key(input logic [55:0] k, input bit dec);
    exp_t e;
    int   n;
    for (int r = 0; r < 16; r++) begin
      n   = dec ? 16 - r : r + 1;
      e.r = 4'(r);
      e.k = model_k(k, n);
      // Published FIPS 46-3 subkeys for the reference key.
      if (k == KeyFips) begin
        if (n == 1)  e.k = 48'h1B02EFFC7072;
        if (n == 2)  e.k = 48'h79AED9DBC9E5;
        if (n == 16) e.k = 48'hCB3D8B0E17F5;
      end
      sb.push_back(e);
    end
  endtask

  // Enters and leaves on a falling edge; after return the first subkey is up.
  task automatic load_key(input logic [55:0] k, input bit dec);
    @(negedge clk);
    tot++;
    if (start_ready !== 1'b1) begin
      bad++;
      $display("FAIL load_ready: start_ready=%b required 1", start_ready);
    end
    start   = 1'b1;
    decrypt = dec;
    pc1_key = k;
    push_key(k, dec);
    @(negedge clk);
    start   = 1'b0;
    decrypt = ~dec;
    pc1_key = ~k;
  endtask

  // mode 0: start low; 1: one start pulse mid-run; 2: start held with key kb.
  task automatic drain(input bit rnd, input int mode, input logic [55:0] kb,
                       input bit db, input int nhs);
    int          hs, guard;
    bit          stalled, rdy;
    logic [47:0] held_k;
    logic [3:0]  held_r;
    exp_t        e;
    hs = 0; guard = 0; stalled = 0; held_k = '0; held_r = '0;
    while (hs < nhs && guard < 300) begin
      tot++;
      if (subkey_valid !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL run_flags: valid=%b done=%b required 1/0", subkey_valid, done);
      end
      if (stalled) begin
        tot++;
        if (subkey !== held_k || round !== held_r) begin
          bad++;
          $display("FAIL stall_hold: subkey=%h round=%0d required %h/%0d",
                   subkey, round, held_k, held_r);
        end
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 2) begin
        start = 1'b1; pc1_key = kb; decrypt = db;
      end else if (mode == 1 && guard == 3) begin
        start = 1'b1; pc1_key = kb; decrypt = db;
      end else begin
        start = 1'b0;
      end
      subkey_ready = rdy;
      if (rdy) begin
        tot++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_empty: handshake %0d with no expected entry", hs);
        end else begin
          e = sb.pop_front();
          if (subkey !== e.k || round !== e.r) begin
            bad++;
            $display("FAIL subkey: round=%0d key=%h required %0d/%h", round, subkey, e.r, e.k);
          end
        end
        hs++;
        stalled = 0;
      end else begin
        stalled = 1;
        held_k  = subkey;
        held_r  = round;
      end
      @(negedge clk);
      guard++;
    end
    if (hs < nhs) begin
      tot++; bad++;
      $display("FAIL timeout: handshakes=%0d required %0d", hs, nhs);
    end
    if (nhs == 16) begin
      tot++;
      if (done !== 1'b1 || start_ready !== 1'b1 || subkey_valid !== 1'b0) begin
        bad++;
        $display("FAIL done_cycle: done=%b ready=%b valid=%b required 1/1/0",
                 done, start_ready, subkey_valid);
      end
      if (!rnd) begin
        tot++;
        if (guard !== 16) begin
          bad++;
          $display("FAIL throughput: cycles=%0d required 16", guard);
        end
      end
      if (mode == 2) begin
        push_key(kb, db);
        @(negedge clk);
        start = 1'b0;
        tot++;
        if (subkey_valid !== 1'b1 || done !== 1'b0) begin
          bad++;
          $display("FAIL b2b_first: valid=%b done=%b required 1/0", subkey_valid, done);
        end
      end else begin
        start = 1'b0;
        @(negedge clk);
        tot++;
        if (done !== 1'b0) begin
          bad++;
          $display("FAIL done_pulse: done=%b required 0", done);
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; pc1_key = '0; subkey_ready = 1'b0;
    #12;
    tot++;
    if (start_ready !== 1'b1 || subkey_valid !== 1'b0 || done !== 1'b0 ||
        subkey !== 48'h0 || round !== 4'd0) begin
      bad++;
      $display("FAIL reset: ready=%b valid=%b done=%b subkey=%h round=%0d required 1/0/0/0/0",
               start_ready, subkey_valid, done, subkey, round);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_encrypt;
    load_key(KeyFips, 1'b0);
    drain(1'b0, 0, '0, 1'b0, 16);
  endtask

  task automatic test_decrypt;
    load_key(KeyFips, 1'b1);
    drain(1'b0, 0, '0, 1'b0, 16);
  endtask

  task automatic test_backpressure;
    load_key(KeyFips, 1'b0);
    drain(1'b1, 0, '0, 1'b0, 16);
  endtask

  task automatic test_start_in_run;
    load_key(KeyFips, 1'b0);
    drain(1'b0, 1, 56'h123456789ABCDE, 1'b1, 16);
  endtask

  task automatic test_reset_mid_run;
    load_key(KeyFips, 1'b0);
    drain(1'b0, 0, '0, 1'b0, 7);
    tot++;
    if (round !== 4'd7) begin
      bad++;
      $display("FAIL pre_abort_round: round=%0d required 7", round);
    end
    rst_n = 1'b0;
    #1;
    tot++;
    if (subkey_valid !== 1'b0 || start_ready !== 1'b1 || done !== 1'b0 ||
        round !== 4'd0 || subkey !== 48'h0) begin
      bad++;
      $display("FAIL abort: valid=%b ready=%b done=%b round=%0d subkey=%h required 0/1/0/0/0",
               subkey_valid, start_ready, done, round, subkey);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tot++;
      if (done !== 1'b0 || subkey_valid !== 1'b0) begin
        bad++;
        $display("FAIL abort_idle: done=%b valid=%b required 0/0", done, subkey_valid);
      end
    end
    load_key(KeyFips, 1'b0);
    drain(1'b0, 0, '0, 1'b0, 16);
  endtask

  task automatic test_back_to_back;
    logic [55:0] kb;
    kb = {$urandom(), 24'($urandom())};
    load_key(KeyFips, 1'b0);
    drain(1'b0, 2, kb, 1'b1, 16);
    drain(1'b1, 0, '0, 1'b0, 16);
  endtask

  task automatic test_random_keys;
    logic [55:0] k;
    for (int i = 0; i < 4; i++) begin
      k = {$urandom(), 24'($urandom())};
      load_key(k, 1'(i & 1));
      drain(1'(i >> 1), 0, '0, 1'b0, 16);
    end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_start_in_run();
    test_reset_mid_run();
    test_back_to_back();
    test_random_keys();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
